// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU driver slice: opcodes, FSM states
// and a few e4m3 encodings.
package alu_pkg;

  localparam logic [3:0] ALU_OP_NOP = 4'b0000;
  localparam logic [3:0] ALU_OP_ADD = 4'b0001;
  localparam logic [3:0] ALU_OP_MUL = 4'b0010;

  localparam logic [7:0] E4M3_ZERO = 8'h00;
  localparam logic [7:0] E4M3_ONE  = 8'h38;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Only add and mul reach the ALU; everything else is answered with an error.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_MUL);
  endfunction

endpackage

// File: rtl/alu_driver_sat_counter.sv
// 8-bit clear/increment counter that saturates at LIMIT-1. The terminal flag
// is high in the LIMIT-th counted cycle, so a phase that must last LIMIT
// cycles ends on the edge where the flag is seen.
module sat_counter #(
  parameter logic [7:0] LIMIT = 8'd1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [7:0] TERM = LIMIT - 8'd1;

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over increment; hold at the terminal value.
  always_comb begin
    // NOTE: default assigned first so every path drives cnt_d; no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == TERM);

endmodule

// File: rtl/alu_driver.sv
// Initiator side of the ALU operand/result interface. Takes add/mul requests
// over valid/ready, settles the ALU with a NOP opcode, waits for the ALU's
// valid (bounded by a timeout) and returns the result or an error.
module alu_driver #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctrl,
  input  logic [7:0] alu_y,
  input  logic       alu_valid,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_y,
  output logic       resp_err
);

  import alu_pkg::*;

  state_e     state_q,      state_d;
  logic [3:0] op_q,         op_d;
  logic [7:0] alu_a_q,      alu_a_d;
  logic [7:0] alu_b_q,      alu_b_d;
  logic [3:0] alu_ctrl_q,   alu_ctrl_d;
  logic       resp_valid_q, resp_valid_d;
  logic [7:0] resp_y_q,     resp_y_d;
  logic       resp_err_q,   resp_err_d;

  logic settle_clr, settle_inc, settle_last;
  logic wait_clr,   wait_inc,   wait_last;

  sat_counter #(.LIMIT(8'(SETTLE_CYCLES))) u_settle_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (settle_clr),
    .inc   (settle_inc),
    .last  (settle_last)
  );

  sat_counter #(.LIMIT(8'(TIMEOUT_CYCLES))) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .last  (wait_last)
  );

  // Next-state and registered-output logic for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    resp_valid_d = resp_valid_q;
    resp_y_d     = resp_y_q;
    resp_err_d   = resp_err_q;
    settle_clr   = 1'b0;
    settle_inc   = 1'b0;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        alu_ctrl_d = ALU_OP_NOP;
        if (req_valid) begin
          if (op_is_legal(req_op)) begin
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            op_d       = req_op;
            settle_clr = 1'b1;
            state_d    = ST_SETTLE;
          end else begin
            // The ALU is left alone: operands keep their previous values.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_y_d     = E4M3_ZERO;
            state_d      = ST_RESP;
          end
        end
      end

      ST_SETTLE: begin
        settle_inc = 1'b1;
        if (settle_last) begin
          alu_ctrl_d = op_q;
          wait_clr   = 1'b1;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wait_inc = 1'b1;
        // A valid in the final allowed cycle beats the timeout.
        if (alu_valid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_y_d     = alu_y;
          alu_ctrl_d   = ALU_OP_NOP;
          state_d      = ST_RESP;
        end else if (wait_last) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_y_d     = E4M3_ZERO;
          alu_ctrl_d   = ALU_OP_NOP;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= ALU_OP_NOP;
      alu_a_q      <= E4M3_ZERO;
      alu_b_q      <= E4M3_ZERO;
      alu_ctrl_q   <= ALU_OP_NOP;
      resp_valid_q <= 1'b0;
      resp_y_q     <= E4M3_ZERO;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign resp_valid = resp_valid_q;
  assign resp_y     = resp_y_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a stub ALU that raises valid a
// programmable number of cycles after the opcode goes non-zero.
module tb_alu_driver;

  logic       clock, reset;
  logic       req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_ctrl;
  logic       alu_valid;
  logic       resp_valid, resp_ready, resp_err;
  logic [7:0] resp_y;

  int checks   = 0;
  int failures = 0;

  logic       stub_en, inj_valid, stub_valid;
  int         stub_delay, stub_cnt;
  logic [3:0] ctrl_hist [0:255];
  int         lat, rdy_hi, ctrl_nz, bad;

  alu_driver #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_y      (alu_y),
    .alu_valid  (alu_valid),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_err   (resp_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hand-computed e4m3 results for the vectors used here.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case ({op, a, b})
      {4'h1, 8'h38, 8'h38}: return 8'h40; // 1.0 + 1.0 = 2.0
      {4'h2, 8'h40, 8'h40}: return 8'h48; // 2.0 * 2.0 = 4.0
      {4'h2, 8'h38, 8'h40}: return 8'h40; // 1.0 * 2.0 = 2.0
      {4'h1, 8'h40, 8'h40}: return 8'h48; // 2.0 + 2.0 = 4.0
      default:              return 8'h7F;
    endcase
  endfunction

  // Stub ALU: counts edges with a non-zero opcode.
  always @(posedge clock or posedge reset) begin
    if (reset) stub_cnt <= 0;
    else if (alu_ctrl == 4'd0) stub_cnt <= 0;
    else if (stub_cnt < 255) stub_cnt <= stub_cnt + 1;
  end

  assign stub_valid = stub_en && (alu_ctrl != 4'd0) && (stub_cnt == stub_delay);
  assign alu_valid  = stub_valid | inj_valid;
  assign alu_y      = alu_model(alu_a, alu_b, alu_ctrl);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Present a request for one edge; returns just after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge clock);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Count edges until resp_valid (bounded), recording alu_ctrl per cycle.
  task automatic wait_resp(output int n, output int ready_hi, output int nz);
    for (int i = 0; i < 256; i++) ctrl_hist[i] = 4'hx;
    n = 0; ready_hi = 0; nz = 0;
    while (resp_valid !== 1'b1 && n < 200) begin
      ctrl_hist[n] = alu_ctrl;
      if (req_ready === 1'b1) ready_hi++;
      if (alu_ctrl !== 4'd0) nz++;
      @(negedge clock);
      n++;
    end
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL %s_hs_valid: got %b want 0", tag, resp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL %s_hs_ready: got %b want 1", tag, req_ready); end
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    // Request held high through reset must not be taken.
    req_valid = 1'b1; req_a = 8'h38; req_b = 8'h38; req_op = 4'h1;
    repeat (2) @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++; if ({alu_a, alu_b, alu_ctrl} !== 20'h0) begin failures++; $display("FAIL rst_alu: got %h want 00000", {alu_a, alu_b, alu_ctrl}); end
    checks++; if ({resp_valid, resp_err, resp_y} !== 10'h0) begin failures++; $display("FAIL rst_resp: got %h want 000", {resp_valid, resp_err, resp_y}); end
    reset = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || alu_a !== 8'h38) begin failures++; $display("FAIL rst_accept: got ready=%b a=%h want ready=0 a=38", req_ready, alu_a); end
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (resp_y !== 8'h40 || lat !== 5) begin failures++; $display("FAIL rst_first_op: got y=%h lat=%0d want y=40 lat=5", resp_y, lat); end
    finish_resp("rst");
  endtask

  task automatic test_add;
    stub_en = 1'b1; stub_delay = 2;
    send(8'h38, 8'h38, 4'h1);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (ctrl_hist[0] !== 4'h0 || ctrl_hist[1] !== 4'h0) begin failures++; $display("FAIL add_settle_ctrl: got %h,%h want 0,0", ctrl_hist[0], ctrl_hist[1]); end
    checks++; if (ctrl_hist[2] !== 4'h1) begin failures++; $display("FAIL add_wait_ctrl: got %h want 1", ctrl_hist[2]); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL add_latency: got %0d want 5", lat); end
    checks++; if (resp_y !== 8'h40 || resp_err !== 1'b0) begin failures++; $display("FAIL add_result: got y=%h err=%b want y=40 err=0", resp_y, resp_err); end
    checks++; if (alu_ctrl !== 4'h0) begin failures++; $display("FAIL add_ctrl_after: got %h want 0", alu_ctrl); end
    finish_resp("add");
  endtask

  task automatic test_mul;
    stub_en = 1'b1; stub_delay = 3;
    send(8'h40, 8'h40, 4'h2);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (rdy_hi !== 0) begin failures++; $display("FAIL mul_ready_low: got %0d cycles ready want 0", rdy_hi); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL mul_latency: got %0d want 6", lat); end
    checks++; if (resp_y !== 8'h48 || resp_err !== 1'b0) begin failures++; $display("FAIL mul_result: got y=%h err=%b want y=48 err=0", resp_y, resp_err); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mul_ready_resp: got %b want 0", req_ready); end
    finish_resp("mul");
  endtask

  task automatic test_illegal;
    send(8'h11, 8'h22, 4'h7);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL ill_valid: got %b want 1", resp_valid); end
    checks++; if (resp_err !== 1'b1 || resp_y !== 8'h00) begin failures++; $display("FAIL ill_resp: got err=%b y=%h want err=1 y=00", resp_err, resp_y); end
    checks++; if (alu_ctrl !== 4'h0) begin failures++; $display("FAIL ill_ctrl: got %h want 0", alu_ctrl); end
    checks++; if (alu_a !== 8'h40 || alu_b !== 8'h40) begin failures++; $display("FAIL ill_operands: got %h,%h want 40,40", alu_a, alu_b); end
    finish_resp("ill");
  endtask

  task automatic test_timeout;
    stub_en = 1'b0;
    send(8'h38, 8'h38, 4'h1);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (ctrl_nz !== 16) begin failures++; $display("FAIL to_wait_cycles: got %0d want 16", ctrl_nz); end
    checks++; if (lat !== 18) begin failures++; $display("FAIL to_latency: got %0d want 18", lat); end
    checks++; if (resp_err !== 1'b1 || resp_y !== 8'h00 || alu_ctrl !== 4'h0) begin failures++; $display("FAIL to_resp: got err=%b y=%h ctrl=%h want err=1 y=00 ctrl=0", resp_err, resp_y, alu_ctrl); end
    finish_resp("to");
    // Valid in the 16th WAIT cycle still counts as a success.
    stub_en = 1'b1; stub_delay = 15;
    send(8'h38, 8'h38, 4'h1);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (lat !== 18 || resp_err !== 1'b0 || resp_y !== 8'h40) begin failures++; $display("FAIL to_last_valid: got lat=%0d err=%b y=%h want lat=18 err=0 y=40", lat, resp_err, resp_y); end
    finish_resp("tolv");
  endtask

  task automatic test_hold;
    stub_en = 1'b1; stub_delay = 1;
    send(8'h38, 8'h40, 4'h2);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (lat !== 4 || resp_y !== 8'h40) begin failures++; $display("FAIL hold_first: got lat=%0d y=%h want lat=4 y=40", lat, resp_y); end
    req_valid = 1'b1; req_a = 8'h40; req_b = 8'h40; req_op = 4'h1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      inj_valid = (i % 2 == 0);
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_y !== 8'h40 || resp_err !== 1'b0 || req_ready !== 1'b0 || alu_ctrl !== 4'h0 || alu_a !== 8'h38) bad++;
    end
    inj_valid = 1'b0; req_valid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
    finish_resp("hold");
    inj_valid = 1'b1;
    @(negedge clock);
    inj_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL idle_glitch: got valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    stub_en = 1'b1; stub_delay = 2;
    resp_ready = 1'b1;
    send(8'h38, 8'h38, 4'h1);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (resp_y !== 8'h40 || lat !== 5) begin failures++; $display("FAIL b2b_first: got y=%h lat=%0d want y=40 lat=5", resp_y, lat); end
    req_valid = 1'b1; req_a = 8'h40; req_b = 8'h40; req_op = 4'h2;
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== 8'h38) begin failures++; $display("FAIL b2b_gap: got valid=%b ready=%b a=%h want valid=0 ready=1 a=38", resp_valid, req_ready, alu_a); end
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || alu_a !== 8'h40) begin failures++; $display("FAIL b2b_accept: got ready=%b a=%h want ready=0 a=40", req_ready, alu_a); end
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (resp_y !== 8'h48 || resp_err !== 1'b0 || lat !== 5) begin failures++; $display("FAIL b2b_second: got y=%h err=%b lat=%0d want y=48 err=0 lat=5", resp_y, resp_err, lat); end
    finish_resp("b2b");
  endtask

  task automatic test_reset_mid;
    stub_en = 1'b0;
    send(8'h40, 8'h40, 4'h1);
    repeat (4) @(negedge clock);
    checks++; if (alu_ctrl !== 4'h1) begin failures++; $display("FAIL mid_in_wait: got ctrl=%h want 1", alu_ctrl); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({alu_a, alu_b, alu_ctrl} !== 20'h0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_async_alu: got %h ready=%b want 00000 ready=1", {alu_a, alu_b, alu_ctrl}, req_ready); end
    checks++; if ({resp_valid, resp_err, resp_y} !== 10'h0) begin failures++; $display("FAIL mid_async_resp: got %h want 000", {resp_valid, resp_err, resp_y}); end
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || alu_ctrl !== 4'h0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL mid_no_resp: got %0d bad cycles want 0", bad); end
    stub_en = 1'b1; stub_delay = 2;
    send(8'h40, 8'h40, 4'h1);
    wait_resp(lat, rdy_hi, ctrl_nz);
    checks++; if (resp_y !== 8'h48 || resp_err !== 1'b0 || lat !== 5) begin failures++; $display("FAIL mid_recover: got y=%h err=%b lat=%0d want y=48 err=0 lat=5", resp_y, resp_err, lat); end
    finish_resp("mid");
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_op = 4'h0;
    resp_ready = 1'b0; inj_valid = 1'b0;
    stub_en = 1'b1; stub_delay = 2;
    test_reset;
    test_add;
    test_mul;
    test_illegal;
    test_timeout;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
Initiator side of the ALU operand/result interface. It accepts e4m3 operation requests from a sequencer over a valid/ready handshake, presents the operands and opcode to the ALU, and waits for the ALU's output-valid flag. It then returns the captured result, or an error, over a second valid/ready handshake. It sits between control logic and the ALU and owns the opcode-settling and timeout policy, so upstream logic never drives the ALU directly.

Parameters:
SETTLE_CYCLES, 2, cycles the ALU opcode is held at 4'b0000 with new operands applied before the real opcode is driven; flushes stale valid from the sub-units; legal range 1..15
TIMEOUT_CYCLES, 16, maximum cycles in WAIT before an error response; legal range 1..255

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  driver can accept a request
req_a  in  8  operand a, e4m3
req_b  in  8  operand b, e4m3
req_op  in  4  4'b0001 = add, 4'b0010 = mul, any other value is illegal
alu_a  out  8  operand a to the ALU
alu_b  out  8  operand b to the ALU
alu_ctrl  out  4  opcode to the ALU
alu_y  in  8  ALU result
alu_valid  in  1  ALU result valid
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_y  out  8  result; 8'h00 when resp_err is set
resp_err  out  1  1 = illegal opcode or timeout

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: state IDLE, alu_a = alu_b = 8'h00, alu_ctrl = 4'b0000, resp_valid = 0, resp_y = 8'h00, resp_err = 0, counters 0.
- All outputs are registered except req_ready, which is 1 exactly when state == IDLE.
- States:
  - IDLE: alu_ctrl = 0. On req_valid && req_ready:
    - Legal opcode: latch a, b, op into alu_a, alu_b and the op register; go to SETTLE with the counter cleared.
    - Illegal opcode: go to RESP with resp_err = 1 and resp_y = 0. The ALU is not touched; alu_a and alu_b keep their old values.
  - SETTLE: alu_ctrl = 0. alu_valid is ignored. After SETTLE_CYCLES cycles in SETTLE, drive alu_ctrl = op and go to WAIT with the counter cleared.
  - WAIT: alu_ctrl = op. On the first cycle with alu_valid = 1:
    - capture alu_y into resp_y, resp_err = 0, resp_valid = 1;
    - alu_ctrl returns to 0 on that same edge;
    - go to RESP.
    If the counter reaches TIMEOUT_CYCLES without alu_valid: resp_err = 1, resp_y = 0, alu_ctrl = 0, go to RESP.
  - RESP: resp_valid = 1 with stable data until resp_ready; on the handshake edge, resp_valid = 0 and state returns to IDLE. With resp_ready held high, the next request can be accepted at the earliest one cycle after the response handshake.
- Latency, legal op, ALU valid seen k cycles into WAIT (k >= 1): resp_valid rises SETTLE_CYCLES + k + 1 edges after the accept edge.
- Illegal op: resp_valid rises on the edge after accept.
- Counters saturate and never wrap.
- alu_valid arriving in the same cycle the timeout count is reached: the valid wins and the response is a success.
- alu_valid pulses in IDLE, SETTLE or RESP are ignored.
- Reset asserted mid-operation: immediate return to reset values, any in-flight response is dropped, and no response is emitted after reset deassertion.
- A req_valid held during reset is not accepted until the first edge after deassertion.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ALU_OP_NOP = 4'b0000, ALU_OP_ADD = 4'b0001, ALU_OP_MUL = 4'b0010;
  - state encoding constants for IDLE, SETTLE, WAIT and RESP;
  - e4m3 constants E4M3_ZERO = 8'h00 and E4M3_ONE = 8'h38.
- One natural sub-module: sat_counter, an 8-bit clear/increment counter with a saturating terminal flag. It is instantiated twice, once for settle and once for timeout; the FSM stays in alu_driver.

Test Plan:
- Stub ALU with valid 2 cycles after ctrl != 0; request a = 8'h38, b = 8'h38, op = ADD (1.0 + 1.0) -> alu_ctrl = 0 for 2 cycles, then 4'b0001; response resp_y = 8'h40, resp_err = 0; latency matches the formula; alu_ctrl = 0 after capture.
- Real ALU, request a = 8'h40, b = 8'h40, op = MUL (2.0 * 2.0) -> resp_y = 8'h48, resp_err = 0; req_ready = 0 from accept until the response handshake.
- Request op = 4'b0111 -> resp_valid on the next edge with resp_err = 1 and resp_y = 8'h00; alu_ctrl never leaves 0 and alu_a/alu_b are unchanged.
- Stub ALU that never asserts valid, TIMEOUT_CYCLES = 16 -> exactly 16 WAIT cycles, then resp_err = 1 and resp_y = 0; a valid injected on cycle 16 instead gives a success response.
- Hold resp_ready = 0 for 5 cycles during RESP -> resp_valid/resp_y/resp_err stable, no new request accepted, and alu_valid glitches have no effect; two back-to-back requests with resp_ready = 1 both complete in order.
- Assert reset during WAIT -> all outputs return to reset values asynchronously (before the next edge), no response is produced afterwards, and a subsequent request completes normally.
